// File: rtl/pe_job_scheduler.sv
// pe_job_scheduler
// Arbitrates between two job requesters and dispatches one job at a time to a
// processing element (PE). The PE is started with a single-cycle pulse. The
// scheduler waits for PE completion, bounded by a timeout, and then presents a
// completion record on a valid/ready handshake.
//
// Ports
//   clk, rst             : rising-edge clock, asynchronous active-low reset
//   req0_* / req1_*      : valid/ready job requests; cfg packs
//                          {tag, wr_psum, filter_size, mode[1:0], stride}
//   pe_ready, pe_done    : PE accepting Start / PE finished the current job
//   pe_start             : one-cycle Start pulse to the PE
//   stride_out, mode_out,
//   filter_size_out,
//   wr_psum_out          : latched PE configuration of the current job
//   cmp_valid, cmp_ready : completion handshake
//   cmp_tag, cmp_src,
//   cmp_timeout          : completion record (source 0=req0, 1=req1)
//   busy                 : high whenever the scheduler is not idle
//   job_count            : completions since reset (wraps)
module pe_job_scheduler #(
  parameter int STRIDE_WIDTH      = 2,
  parameter int FILTER_SIZE_WIDTH = 4,
  parameter int TAG_WIDTH         = 4,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int CNT_WIDTH         = 16,
  parameter int CFG_W = TAG_WIDTH + 1 + FILTER_SIZE_WIDTH + 2 + STRIDE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [CFG_W-1:0]             req0_cfg,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [CFG_W-1:0]             req1_cfg,
  input  logic                         pe_ready,
  input  logic                         pe_done,
  output logic                         pe_start,
  output logic [STRIDE_WIDTH-1:0]      stride_out,
  output logic [1:0]                   mode_out,
  output logic [FILTER_SIZE_WIDTH-1:0] filter_size_out,
  output logic                         wr_psum_out,
  output logic                         cmp_valid,
  input  logic                         cmp_ready,
  output logic [TAG_WIDTH-1:0]         cmp_tag,
  output logic                         cmp_src,
  output logic                         cmp_timeout,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         job_count
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  // Field positions inside a descriptor, LSB first
  localparam int MODE_LSB = STRIDE_WIDTH;
  localparam int FS_LSB   = MODE_LSB + 2;
  localparam int WR_BIT   = FS_LSB + FILTER_SIZE_WIDTH;
  localparam int TAG_LSB  = WR_BIT + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [STRIDE_WIDTH-1:0]      stride_q;
  logic [1:0]                   mode_q;
  logic [FILTER_SIZE_WIDTH-1:0] fs_q;
  logic                         wr_psum_q;
  logic [TAG_WIDTH-1:0]         tag_q;
  logic                         src_q;
  logic                         timeout_q;
  logic [WAIT_W-1:0]            wait_cnt_q;
  logic [CNT_WIDTH-1:0]         job_count_q;
  logic                         last_q;

  logic             grant0, grant1, accept, accept_src;
  logic [CFG_W-1:0] sel_cfg;

  // Round-robin grant, recomputed every cycle. On a tie the requester that
  // was not served last wins; last_q resets to 1 so req0 wins the first tie.
  // Ready is qualified with rst so both readies stay low while reset is held.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == S_IDLE) & rst & grant0;
    req1_ready = (state_q == S_IDLE) & rst & grant1;
    accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    accept_src = req1_ready;
    sel_cfg    = accept_src ? req1_cfg : req0_cfg;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. pe_start follows pe_ready only in
  // START, and the same edge moves on to WAIT, so the pulse is one cycle.
  // In WAIT a done on the final counted cycle still wins over the timeout.
  always_comb begin
    state_d   = state_q;
    pe_start  = 1'b0;
    cmp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        pe_start = pe_ready;
        if (pe_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_done || (wait_cnt_q == WAIT_LAST)) state_d = S_REPORT;
      end
      S_REPORT: begin
        cmp_valid = 1'b1;
        if (cmp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job datapath: descriptor latch on accept, wait counter, timeout flag,
  // completion counter and round-robin pointer update on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q    <= '0;
      mode_q      <= '0;
      fs_q        <= '0;
      wr_psum_q   <= 1'b0;
      tag_q       <= '0;
      src_q       <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt_q  <= '0;
      job_count_q <= '0;
      last_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            stride_q  <= sel_cfg[STRIDE_WIDTH-1:0];
            mode_q    <= sel_cfg[MODE_LSB +: 2];
            fs_q      <= sel_cfg[FS_LSB +: FILTER_SIZE_WIDTH];
            wr_psum_q <= sel_cfg[WR_BIT];
            tag_q     <= sel_cfg[TAG_LSB +: TAG_WIDTH];
            src_q     <= accept_src;
            timeout_q <= 1'b0;
          end
        end
        S_START: begin
          if (pe_ready) wait_cnt_q <= '0;
        end
        S_WAIT: begin
          if (pe_done) begin
            timeout_q <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_REPORT: begin
          if (cmp_ready) begin
            job_count_q <= job_count_q + CNT_WIDTH'(1);
            last_q      <= src_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign stride_out      = stride_q;
  assign mode_out        = mode_q;
  assign filter_size_out = fs_q;
  assign wr_psum_out     = wr_psum_q;
  assign cmp_tag         = tag_q;
  assign cmp_src         = src_q;
  assign cmp_timeout     = timeout_q;
  assign busy            = (state_q != S_IDLE);
  assign job_count       = job_count_q;

endmodule

// File: tb/tb_pe_job_scheduler.sv
// tb_pe_job_scheduler
// Randomized, self-checking bench for pe_job_scheduler. A transaction-level
// model tracks the round-robin pointer and completion count and predicts the
// grant, configuration, completion record and wait latency of each job.
module tb_pe_job_scheduler;

  localparam int SW    = 2;
  localparam int FW    = 4;
  localparam int TW    = 4;
  localparam int TO    = 8;
  localparam int CW    = 16;
  localparam int CFG_W = TW + 1 + FW + 2 + SW;

  typedef struct {
    int tag;
    int wr;
    int fs;
    int mode;
    int stride;
  } job_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [CFG_W-1:0] req0_cfg, req1_cfg;
  logic             pe_ready, pe_done, pe_start;
  logic [SW-1:0]    stride_out;
  logic [1:0]       mode_out;
  logic [FW-1:0]    filter_size_out;
  logic             wr_psum_out;
  logic             cmp_valid, cmp_ready;
  logic [TW-1:0]    cmp_tag;
  logic             cmp_src, cmp_timeout, busy;
  logic [CW-1:0]    job_count;

  int   vectors     = 0;
  int   miscompares = 0;
  logic model_last;
  int   model_count;

  pe_job_scheduler #(
    .STRIDE_WIDTH(SW), .FILTER_SIZE_WIDTH(FW), .TAG_WIDTH(TW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cfg(req0_cfg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cfg(req1_cfg),
    .pe_ready(pe_ready), .pe_done(pe_done), .pe_start(pe_start),
    .stride_out(stride_out), .mode_out(mode_out),
    .filter_size_out(filter_size_out), .wr_psum_out(wr_psum_out),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_tag(cmp_tag), .cmp_src(cmp_src), .cmp_timeout(cmp_timeout),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  // Global watchdog so a wedged run still terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no_finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [CFG_W-1:0] mkCfg(input job_t j);
    return {TW'(j.tag), 1'(j.wr), FW'(j.fs), 2'(j.mode), SW'(j.stride)};
  endfunction

  function automatic job_t randJob();
    job_t j;
    j.tag    = int'($urandom_range(0, (1 << TW) - 1));
    j.wr     = int'($urandom_range(0, 1));
    j.fs     = int'($urandom_range(0, (1 << FW) - 1));
    j.mode   = int'($urandom_range(0, 3));
    j.stride = int'($urandom_range(0, (1 << SW) - 1));
    return j;
  endfunction

  function automatic job_t mkJob(input int tag, wr, fs, mode, stride);
    job_t j;
    j.tag = tag; j.wr = wr; j.fs = fs; j.mode = mode; j.stride = stride;
    return j;
  endfunction

  // Spec-level grant rule: single requester wins; on a tie the one not
  // served last wins.
  function automatic logic modelGrant(input logic v0, input logic v1);
    if (v0 && v1) return ~model_last;
    return v1;
  endfunction

  task automatic checkConfig(input string name, input job_t g);
    checkOutput({name, "_stride"}, 32'(stride_out), g.stride);
    checkOutput({name, "_mode"}, 32'(mode_out), g.mode);
    checkOutput({name, "_fs"}, 32'(filter_size_out), g.fs);
    checkOutput({name, "_wr"}, 32'(wr_psum_out), g.wr);
  endtask

  // One full job: optional withdrawn request, grant, PE stall, wait for
  // done or timeout, completion backpressure, then model update.
  task automatic applyStimulus(input job_t j0, input job_t j1,
                               input logic v0, input logic v1,
                               input int stall, input int done_at,
                               input int bp, input bit probe);
    logic exp_src, exp_to, pv0, pv1;
    job_t g;
    int   k, exp_wait;
    if (probe) begin
      pv0 = 1'($urandom); pv1 = 1'($urandom);
      req0_valid = pv0; req1_valid = pv1;
      req0_cfg = mkCfg(randJob()); req1_cfg = mkCfg(randJob());
      #1;
      checkOutput("probe_ready0", 32'(req0_ready),
                  32'((pv0 | pv1) & ~modelGrant(pv0, pv1) & pv0));
      checkOutput("probe_ready1", 32'(req1_ready),
                  32'((pv0 | pv1) & modelGrant(pv0, pv1) & pv1));
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      checkOutput("probe_no_accept", 32'(busy), 0);
    end
    exp_src = modelGrant(v0, v1);
    g = exp_src ? j1 : j0;
    req0_valid = v0; req1_valid = v1;
    req0_cfg = mkCfg(j0); req1_cfg = mkCfg(j1);
    #1;
    checkOutput("grant_ready0", 32'(req0_ready), 32'(~exp_src & v0));
    checkOutput("grant_ready1", 32'(req1_ready), 32'(exp_src & v1));
    checkOutput("idle_busy", 32'(busy), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; pe_ready = 1'b0;
    checkOutput("start_busy", 32'(busy), 1);
    checkConfig("start", g);
    for (int i = 0; i < stall; i++) begin
      pe_done = 1'($urandom);
      #1;
      checkOutput("stall_pe_start", 32'(pe_start), 0);
      checkOutput("stall_busy", 32'(busy), 1);
      tick();
    end
    pe_done = 1'b0; pe_ready = 1'b1;
    #1;
    checkOutput("pe_start_pulse", 32'(pe_start), 1);
    tick();
    #1;
    checkOutput("pe_start_single", 32'(pe_start), 0);
    pe_ready = 1'($urandom);
    k = 1;
    while (k <= 40) begin
      if (cmp_valid) break;
      pe_done = (k == done_at);
      tick();
      k++;
    end
    pe_done = 1'b0;
    exp_wait = (done_at < TO) ? done_at : TO;
    exp_to   = (done_at > TO);
    checkOutput("cmp_valid_seen", 32'(cmp_valid), 1);
    checkOutput("wait_cycles", k - 1, exp_wait);
    for (int i = 0; i < bp; i++) begin
      cmp_ready = 1'b0;
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      pe_done = 1'($urandom);
      #1;
      checkOutput("bp_cmp_valid", 32'(cmp_valid), 1);
      checkOutput("bp_cmp_tag", 32'(cmp_tag), g.tag);
      checkOutput("bp_cmp_src", 32'(cmp_src), 32'(exp_src));
      checkOutput("bp_cmp_timeout", 32'(cmp_timeout), 32'(exp_to));
      checkOutput("bp_no_ready", 32'({req0_ready, req1_ready}), 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; pe_done = 1'b0; cmp_ready = 1'b1;
    #1;
    checkOutput("cmp_tag", 32'(cmp_tag), g.tag);
    checkOutput("cmp_src", 32'(cmp_src), 32'(exp_src));
    checkOutput("cmp_timeout", 32'(cmp_timeout), 32'(exp_to));
    checkConfig("report", g);
    tick();
    cmp_ready = 1'b0;
    model_count = (model_count + 1) % (1 << CW);
    model_last  = exp_src;
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_cmp_valid", 32'(cmp_valid), 0);
    checkOutput("job_count", 32'(job_count), model_count);
    checkConfig("idle_hold", g);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ready"}, 32'({req0_ready, req1_ready}), 0);
    checkOutput({name, "_pe_start"}, 32'(pe_start), 0);
    checkOutput({name, "_cfg"},
                32'({stride_out, mode_out, filter_size_out, wr_psum_out}), 0);
    checkOutput({name, "_cmp"},
                32'({cmp_valid, cmp_tag, cmp_src, cmp_timeout}), 0);
    checkOutput({name, "_busy"}, 32'(busy), 0);
    checkOutput({name, "_job_count"}, 32'(job_count), 0);
  endtask

  // Start a job, let it sit in WAIT, then pulse reset between clock edges.
  task automatic resetMidWait();
    req0_valid = 1'b1; req0_cfg = mkCfg(mkJob(9, 1, 7, 2, 3));
    tick();
    req0_valid = 1'b0; pe_ready = 1'b1;
    tick();
    pe_ready = 1'b0;
    tick(); tick(); tick();
    req0_valid = 1'b1; req1_valid = 1'b1; pe_ready = 1'b1;
    #2 rst = 1'b0;
    #1 checkAllZero("async_reset");
    tick();
    checkAllZero("held_reset");
    req0_valid = 1'b0; req1_valid = 1'b0; pe_ready = 1'b0;
    rst = 1'b1;
    model_count = 0;
    model_last  = 1'b1;
  endtask

  initial begin
    job_t a, b;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_cfg = '0; req1_cfg = '0;
    pe_ready = 1'b0; pe_done = 1'b0; cmp_ready = 1'b0;
    model_count = 0; model_last = 1'b1;
    #1 checkAllZero("por");
    tick(); tick();
    rst = 1'b1;

    // Single job, released straight after reset
    a = mkJob(5, 1, 10, 3, 1);
    applyStimulus(a, randJob(), 1'b1, 1'b0, 0, 6, 0, 1'b0);
    // PE stalled for 20 cycles
    applyStimulus(randJob(), randJob(), 1'b0, 1'b1, 20, 3, 0, 1'b0);
    // Timeout, then done on the last counted cycle
    applyStimulus(randJob(), randJob(), 1'b1, 1'b0, 0, 1000, 0, 1'b0);
    applyStimulus(randJob(), randJob(), 1'b1, 1'b0, 0, TO, 0, 1'b0);
    // Completion backpressure
    applyStimulus(randJob(), randJob(), 1'b1, 1'b1, 1, 2, 10, 1'b0);
    // Reset mid-job; arbitration must restart with req0 winning the tie
    resetMidWait();
    a = mkJob(1, 0, 4, 1, 2);
    b = mkJob(2, 1, 6, 2, 0);
    for (int n = 0; n < 4; n++)
      applyStimulus(a, b, 1'b1, 1'b1, 0, int'($urandom_range(1, 5)), 0, 1'b0);

    // Randomized jobs
    for (int n = 0; n < 40; n++) begin
      logic rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      applyStimulus(randJob(), randJob(), rv0, rv1,
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
